// File: rtl/sweep_ctrl.sv
// Exhaustive 4-input sweep controller. Drives every vector {X,Y,W,Z} = 0..15,
// lets the circuits under test settle, then compares a reference output against
// a gate-level output with four-state semantics and reports the results.
module sweep_ctrl #(
  parameter int unsigned SETTLE = 1  // wait cycles between apply and sample, 1..7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       S_ref,
  input  logic       S_dut,
  output logic       X,
  output logic       Y,
  output logic       W,
  output logic       Z,
  output logic       busy,
  output logic       done,
  output logic       match,
  output logic [4:0] err_count,
  output logic [3:0] first_err,
  output logic       first_err_valid,
  output logic [4:0] ones_count
);

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    WAIT,
    SAMPLE,
    DONE
  } state_e;

  localparam logic [2:0] SETTLE_CNT = 3'(SETTLE);

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] vec_q, vec_d;
  logic [2:0] settle_q, settle_d;
  logic [4:0] err_q, err_d;
  logic [4:0] ones_q, ones_d;
  logic [3:0] first_err_q, first_err_d;
  logic       fev_q, fev_d;
  logic       match_q, match_d;

  // An x or z on either side is a mismatch; only a known 1 counts as a one.
  logic mismatch;
  logic ref_one;
  assign mismatch = (S_ref !== S_dut);
  assign ref_one  = (S_ref === 1'b1);

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      vec_q       <= '0;
      settle_q    <= '0;
      err_q       <= '0;
      ones_q      <= '0;
      first_err_q <= '0;
      fev_q       <= 1'b0;
      match_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      idx_q       <= idx_d;
      vec_q       <= vec_d;
      settle_q    <= settle_d;
      err_q       <= err_d;
      ones_q      <= ones_d;
      first_err_q <= first_err_d;
      fev_q       <= fev_d;
      match_q     <= match_d;
    end
  end

  // Next-state and datapath update for the sweep sequence.
  always_comb begin
    // NOTE: every _d defaults to its register so no path can infer a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    vec_d       = vec_q;
    settle_d    = settle_q;
    err_d       = err_q;
    ones_d      = ones_q;
    first_err_d = first_err_q;
    fev_d       = fev_q;
    match_d     = match_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          idx_d       = '0;
          err_d       = '0;
          ones_d      = '0;
          first_err_d = '0;
          fev_d       = 1'b0;
          match_d     = 1'b0;
          state_d     = APPLY;
        end
      end
      APPLY: begin
        vec_d    = idx_q;
        settle_d = SETTLE_CNT;
        state_d  = WAIT;
      end
      WAIT: begin
        settle_d = settle_q - 3'd1;
        if (settle_q == 3'd1) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (mismatch) begin
          // At most 16 samples per sweep, so the 5-bit count never wraps.
          err_d = err_q + 5'd1;
          if (!fev_q) begin
            first_err_d = idx_q;
            fev_d       = 1'b1;
          end
        end
        if (ref_one) ones_d = ones_q + 5'd1;
        if (idx_q == 4'd15) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = APPLY;
        end
      end
      DONE: begin
        match_d = (err_q == 5'd0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign {X, Y, W, Z}    = vec_q;
  assign busy            = (state_q != IDLE);
  assign done            = (state_q == DONE);
  assign match           = match_q;
  assign err_count       = err_q;
  assign first_err       = first_err_q;
  assign first_err_valid = fev_q;
  assign ones_count      = ones_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Bench for sweep_ctrl: a SETTLE=1 instance driven by single-sweep scenarios
// through a scoreboard, plus a SETTLE=3 instance with start held high.
module tb_sweep_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Instance A: SETTLE = 1
  logic       start_a, s_ref_a, s_dut_a;
  logic       xa, ya, wa, za, busy_a, done_a, match_a, fev_a;
  logic [4:0] err_a, ones_a;
  logic [3:0] ferr_a;

  sweep_ctrl #(.SETTLE(1)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .S_ref(s_ref_a), .S_dut(s_dut_a),
    .X(xa), .Y(ya), .W(wa), .Z(za), .busy(busy_a), .done(done_a), .match(match_a),
    .err_count(err_a), .first_err(ferr_a), .first_err_valid(fev_a), .ones_count(ones_a)
  );

  // Instance B: SETTLE = 3, reference and gate-level both X&Y
  logic       start_b, s_b;
  logic       xb, yb, wb, zb, busy_b, done_b, match_b, fev_b;
  logic [4:0] err_b, ones_b;
  logic [3:0] ferr_b;

  sweep_ctrl #(.SETTLE(3)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .S_ref(s_b), .S_dut(s_b),
    .X(xb), .Y(yb), .W(wb), .Z(zb), .busy(busy_b), .done(done_b), .match(match_b),
    .err_count(err_b), .first_err(ferr_b), .first_err_valid(fev_b), .ones_count(ones_b)
  );

  always_comb s_b = xb & yb;

  // Circuits under test for instance A, selected by mode:
  // 0: ref = X&Y, dut = ref
  // 1: ref = X&Y, dut inverted at index 5
  // 2: ref = 1, dut = 0
  // 3: ref = X|Z, dut = x at index 3
  int mode;

  function automatic logic ref_fn(input int m, input logic [3:0] v);
    case (m)
      2:       return 1'b1;
      3:       return v[3] | v[0];
      default: return v[3] & v[2];
    endcase
  endfunction

  function automatic logic dut_fn(input int m, input logic [3:0] v);
    logic r;
    r = ref_fn(m, v);
    case (m)
      1:       return (v == 4'd5) ? ~r : r;
      2:       return 1'b0;
      3:       return (v == 4'd3) ? 1'bx : r;
      default: return r;
    endcase
  endfunction

  always_comb begin
    s_ref_a = ref_fn(mode, {xa, ya, wa, za});
    s_dut_a = dut_fn(mode, {xa, ya, wa, za});
  end

  typedef struct packed {
    logic [4:0] err;
    logic [4:0] ones;
    logic [3:0] ferr;
    logic       fev;
    logic       match;
  } exp_t;

  exp_t sb_q[$];

  // Reference result of one full sweep over all 16 vectors.
  function automatic exp_t model(input int m);
    exp_t e;
    logic r, d;
    e = '0;
    for (int i = 0; i < 16; i++) begin
      r = ref_fn(m, 4'(i));
      d = dut_fn(m, 4'(i));
      if (r !== d) begin
        if (!e.fev) begin
          e.ferr = 4'(i);
          e.fev  = 1'b1;
        end
        e.err = e.err + 5'd1;
      end
      if (r === 1'b1) e.ones = e.ones + 5'd1;
    end
    e.match = (e.err == 5'd0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One sweep on instance A; optionally pulse start while busy.
  task automatic run_sweep(input int m, input bit poke_busy);
    exp_t        e;
    int unsigned t0;
    bit          seen;
    mode = m;
    @(negedge clk);
    check("idle_before", busy_a, 1'b0);
    start_a = 1'b1;
    t0 = cyc + 1;
    sb_q.push_back(model(m));
    @(negedge clk);
    start_a = 1'b0;
    check("busy_after_start", busy_a, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (poke_busy && i == 20) start_a = 1'b1;
      if (poke_busy && i == 21) start_a = 1'b0;
      if (done_a) seen = 1'b1;
    end
    check("done_seen", seen, 1'b1);
    if (seen && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("latency", cyc - t0, 32'd48);
      check("busy_at_done", busy_a, 1'b1);
      check("err_count", err_a, e.err);
      check("ones_count", ones_a, e.ones);
      check("first_err", ferr_a, e.ferr);
      check("first_err_valid", fev_a, e.fev);
      @(negedge clk);
      check("done_one_cycle", done_a, 1'b0);
      check("match", match_a, e.match);
      check("busy_idle", busy_a, 1'b0);
      check("vec_hold_1111", {xa, ya, wa, za}, 4'hf);
      @(negedge clk);
      check("start_not_queued", busy_a, 1'b0);
      check("err_hold", err_a, e.err);
      check("match_hold", match_a, e.match);
    end else begin
      sb_q.delete();
    end
  endtask

  task automatic reset_mid_sweep();
    bit found;
    bit done_seen;
    mode = 2;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if ({xa, ya, wa, za} == 4'd7) found = 1'b1;
    end
    check("reached_idx7", found, 1'b1);
    check("err_before_reset", err_a, 5'd7);
    #2;
    reset = 1'b1;
    #1;
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_vec", {xa, ya, wa, za}, 4'h0);
    check("rst_err", err_a, 5'd0);
    check("rst_ones", ones_a, 5'd0);
    check("rst_ferr", ferr_a, 4'd0);
    check("rst_fev", fev_a, 1'b0);
    check("rst_match", match_a, 1'b0);
    done_seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done_a) done_seen = 1'b1;
    end
    reset = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (done_a || busy_a) done_seen = 1'b1;
    end
    check("no_done_after_abort", done_seen, 1'b0);
  endtask

  task automatic back_to_back();
    int unsigned td[3];
    int unsigned t0;
    int          nd;
    int          run;
    logic [3:0]  pv, v;
    nd = 0;
    run = 0;
    pv = {xb, yb, wb, zb};
    @(negedge clk);
    start_b = 1'b1;
    t0 = cyc + 1;
    for (int i = 0; i < 400 && nd < 3; i++) begin
      @(negedge clk);
      v = {xb, yb, wb, zb};
      if (v == pv) begin
        run++;
      end else begin
        if (pv >= 4'd1 && pv <= 4'd14) check("b_vec_stable", run, 32'd5);
        pv = v;
        run = 1;
      end
      if (done_b) begin
        td[nd] = cyc;
        nd++;
        check("b_err_count", err_b, 5'd0);
        check("b_ones_count", ones_b, 5'd4);
      end
    end
    start_b = 1'b0;
    check("b_dones", nd, 32'd3);
    if (nd == 3) begin
      check("b_first_latency", td[0] - t0, 32'd80);
      check("b_period_1", td[1] - td[0], 32'd82);
      check("b_period_2", td[2] - td[1], 32'd82);
    end
    @(negedge clk);
    check("b_match", match_b, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    mode    = 0;
    #1;
    check("reset_busy", busy_a, 1'b0);
    check("reset_done", done_a, 1'b0);
    check("reset_vec", {xa, ya, wa, za}, 4'h0);
    check("reset_err", err_a, 5'd0);
    check("reset_ones", ones_a, 5'd0);
    check("reset_match", match_a, 1'b0);
    check("reset_fev", fev_a, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_sweep(0, 1'b0);  // all match, ones = 4
    run_sweep(1, 1'b0);  // single mismatch at index 5
    run_sweep(2, 1'b1);  // all mismatch, start pulsed while busy
    run_sweep(3, 1'b0);  // x on gate-level output at index 3
    reset_mid_sweep();
    run_sweep(0, 1'b0);  // full sweep after abort
    back_to_back();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sweep_ctrl.md
SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 Parameter: SETTLE, default 1, number of wait cycles between applying a vector and sampling the results; legal range 1..7.
REQ-002 Ports (name, direction, width, meaning):
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request one exhaustive sweep; sampled only in IDLE.
- S_ref  input  1  output of the reference expression under test.
- S_dut  input  1  output of the gate-level circuit under test.
- X, Y, W, Z  output  1 each  registered stimulus vector; X is MSB, Z is LSB.
- busy  output  1  high from sweep acceptance until DONE is left.
- done  output  1  one-cycle pulse at sweep end.
- match  output  1  high when the last completed sweep had zero mismatches.
- err_count  output  5  mismatches in the current/last sweep, 0..16.
- first_err  output  4  vector index {X,Y,W,Z} of the first mismatch.
- first_err_valid  output  1  first_err holds a captured index.
- ones_count  output  5  vectors where S_ref==1, 0..16.
REQ-003 Clock and reset SHALL be one clock, clk; reset asynchronous and active-high.

Function
REQ-004 FSM states SHALL be IDLE, APPLY, WAIT, SAMPLE, DONE, with a 4-bit vector index idx and a 3-bit settle counter.
REQ-005 IDLE, start==1: idx<=0; err_count, ones_count, first_err, first_err_valid, match cleared; go to APPLY. IDLE, start==0: stay.
REQ-006 APPLY (1 cycle): {X,Y,W,Z}<=idx, settle counter<=SETTLE, go to WAIT.
REQ-007 WAIT: decrement the settle counter each cycle; leave for SAMPLE after exactly SETTLE cycles in WAIT.
REQ-008 SAMPLE (1 cycle): compare S_ref and S_dut with four-state semantics. A mismatch is any differing value, including either input being x or z.
REQ-009 On a SAMPLE mismatch: err_count increments. If first_err_valid==0, then first_err<=idx and first_err_valid<=1.
REQ-010 On SAMPLE with S_ref==1 (known 1 only): ones_count increments.
REQ-011 Leaving SAMPLE: idx==15 goes to DONE; otherwise idx<=idx+1 and go to APPLY.
REQ-012 DONE (1 cycle): done=1; match<=(err_count==0), including the final sample's update; go to IDLE.
REQ-013 Per-vector cost SHALL be SETTLE+2 cycles. done SHALL assert 16*(SETTLE+2) cycles after the edge at which start was accepted.
REQ-014 {X,Y,W,Z} SHALL remain stable from APPLY through SAMPLE of each vector. After a sweep they hold 1111 until the next APPLY.
REQ-015 busy SHALL be 1 in APPLY, WAIT, SAMPLE and DONE, and 0 in IDLE. start while busy SHALL be ignored, not queued.
REQ-016 Result outputs SHALL hold their values after DONE until the next accepted start.
REQ-017 With start held high continuously, sweeps SHALL run back-to-back with done period 16*(SETTLE+2)+2 cycles (DONE plus one IDLE cycle).
REQ-018 err_count and ones_count SHALL saturate naturally at 16 (5 bits, no wrap); no other arithmetic wraps except idx 15->0 on a new start.

Reset
REQ-019 reset==1 SHALL immediately force, regardless of clk: state IDLE, idx=0, X=Y=W=Z=0, busy=0, done=0, match=0, err_count=0, first_err=0, first_err_valid=0, ones_count=0.
REQ-020 Reset asserted mid-sweep SHALL abort the sweep with no done pulse. After reset releases, the block waits in IDLE for a new start.

Verification
REQ-021 SETTLE=1, S_ref=S_dut=X&Y, one start pulse -> done at cycle 48 after acceptance; match=1, err_count=0, ones_count=4, first_err_valid=0.
REQ-022 S_dut equals S_ref except inverted at index 5 (X=0,Y=1,W=0,Z=1) -> err_count=1, first_err=5, first_err_valid=1, match=0.
REQ-023 S_ref tied 1, S_dut tied 0 -> err_count=16, ones_count=16, first_err=0, match=0.
REQ-024 S_dut driven x at index 3, otherwise equal to S_ref -> err_count=1, first_err=3.
REQ-025 reset asserted at idx=7 in WAIT, between clock edges -> all outputs 0 immediately; no done pulse; a new start yields a full 16-vector sweep.
REQ-026 SETTLE=3, start held high -> done pulses every 82 cycles; a start pulse during busy changes nothing; {X,Y,W,Z} is stable for 5 cycles per vector.
